// File: rtl/aes_decrypt_top.sv
// Iterative AES-128 inverse cipher: forward key expansion to rk10, then one inverse round per clock.
// Optional macro AES_DEC_KEY_CACHE_EN caches the last cipher key and its rk10 to skip expansion.
module aes_decrypt_top #(
  parameter int NR = 10
) (
  input  logic         AES_clk,
  input  logic         AES_rst,
  input  logic         AES_en,
  input  logic [127:0] AES_data_in,
  input  logic [127:0] AES_key_in,
  output logic         AES_busy,
  output logic [127:0] AES_data_out,
  output logic         AES_data_out_valid
);
  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] KEYEXP = 2'd1;
  localparam logic [1:0] ADDKEY = 2'd2;
  localparam logic [1:0] ROUND  = 2'd3;
  localparam logic [3:0] RLAST  = 4'(NR);
  localparam logic [3:0] RFIRST = 4'(NR - 1);

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  // a^254 by square-and-multiply; maps 0 to 0
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] p, r;
    p = a;
    r = 8'h01;
    for (int k = 1; k < 8; k++) begin
      p = gf_mul(p, p);
      r = gf_mul(r, p);
    end
    return r;
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] b;
    b = gf_inv(a);
    return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [7:0] inv_sbox(input logic [7:0] a);
    return gf_inv({a[6:0], a[7]} ^ {a[4:0], a[7:5]} ^ {a[1:0], a[7:2]} ^ 8'h05);
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] i);
    case (i)
      4'd1:    return 8'h01;
      4'd2:    return 8'h02;
      4'd3:    return 8'h04;
      4'd4:    return 8'h08;
      4'd5:    return 8'h10;
      4'd6:    return 8'h20;
      4'd7:    return 8'h40;
      4'd8:    return 8'h80;
      4'd9:    return 8'h1b;
      4'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  function automatic logic [31:0] inv_mix_col(input logic [31:0] col);
    logic [7:0] a[4], x2[4], x4[4], x8[4], m9[4], mb[4], md[4], me[4];
    for (int i = 0; i < 4; i++) begin
      a[i]  = col[31-8*i -: 8];
      x2[i] = xtime(a[i]);
      x4[i] = xtime(x2[i]);
      x8[i] = xtime(x4[i]);
      m9[i] = x8[i] ^ a[i];
      mb[i] = x8[i] ^ x2[i] ^ a[i];
      md[i] = x8[i] ^ x4[i] ^ a[i];
      me[i] = x8[i] ^ x4[i] ^ x2[i];
    end
    return {me[0] ^ mb[1] ^ md[2] ^ m9[3], m9[0] ^ me[1] ^ mb[2] ^ md[3],
            md[0] ^ m9[1] ^ me[2] ^ mb[3], mb[0] ^ md[1] ^ m9[2] ^ me[3]};
  endfunction

  logic [1:0]   fsm_q;
  logic [3:0]   rcnt_q;
  logic [127:0] state_q, key_q, dout_q;
  logic         valid_q;

  logic [31:0]  w0, w1, w2, w3, b1, b2, b3, sub_in, rot_w, sub_out, n0;
  logic [3:0]   rc_idx;
  logic [127:0] key_fwd, key_back, isb, arks, mixed;

  // The same four S-boxes serve forward expansion and the backward key step
  always_comb begin
    w0 = key_q[127:96];
    w1 = key_q[95:64];
    w2 = key_q[63:32];
    w3 = key_q[31:0];
    b3 = w3 ^ w2;
    b2 = w2 ^ w1;
    b1 = w1 ^ w0;
    sub_in = (fsm_q == KEYEXP) ? w3 : b3;
    rc_idx = (fsm_q == KEYEXP) ? rcnt_q : rcnt_q + 4'd1;
    rot_w  = {sub_in[23:0], sub_in[31:24]};
  end

  for (genvar i = 0; i < 4; i++) begin : g_sbox
    assign sub_out[8*i +: 8] = sbox(rot_w[8*i +: 8]);
  end

  assign n0       = w0 ^ sub_out ^ {rcon(rc_idx), 24'h0};
  assign key_fwd  = {n0, n0 ^ w1, n0 ^ w1 ^ w2, n0 ^ w1 ^ w2 ^ w3};
  assign key_back = {n0, b1, b2, b3};

  for (genvar i = 0; i < 16; i++) begin : g_inv_sbox
    localparam int R = i % 4;
    localparam int C = i / 4;
    localparam int SRC = R + 4 * ((C - R + 4) % 4);
    assign isb[127-8*i -: 8] = inv_sbox(state_q[127-8*SRC -: 8]);
  end

  assign arks = isb ^ key_back;

  for (genvar c = 0; c < 4; c++) begin : g_mix
    assign mixed[127-32*c -: 32] = inv_mix_col(arks[127-32*c -: 32]);
  end

`ifdef AES_DEC_KEY_CACHE_EN
  logic [127:0] pend_key_q, cache_key_q, cache_rk_q;
  logic         cache_vld_q;
`endif

  always_ff @(posedge AES_clk or posedge AES_rst) begin
    if (AES_rst) begin
      fsm_q   <= IDLE;
      rcnt_q  <= 4'd0;
      state_q <= '0;
      key_q   <= '0;
      dout_q  <= '0;
      valid_q <= 1'b0;
`ifdef AES_DEC_KEY_CACHE_EN
      pend_key_q  <= '0;
      cache_key_q <= '0;
      cache_rk_q  <= '0;
      cache_vld_q <= 1'b0;
`endif
    end else begin
      valid_q <= 1'b0;
      case (fsm_q)
        IDLE: begin
          if (AES_en) begin
            state_q <= AES_data_in;
            rcnt_q  <= 4'd1;
`ifdef AES_DEC_KEY_CACHE_EN
            if (cache_vld_q && (AES_key_in == cache_key_q)) begin
              key_q <= cache_rk_q;
              fsm_q <= ADDKEY;
            end else begin
              key_q      <= AES_key_in;
              pend_key_q <= AES_key_in;
              fsm_q      <= KEYEXP;
            end
`else
            key_q <= AES_key_in;
            fsm_q <= KEYEXP;
`endif
          end
        end
        KEYEXP: begin
          key_q  <= key_fwd;
          rcnt_q <= rcnt_q + 4'd1;
          if (rcnt_q == RLAST) begin
            fsm_q <= ADDKEY;
`ifdef AES_DEC_KEY_CACHE_EN
            cache_key_q <= pend_key_q;
            cache_rk_q  <= key_fwd;
            cache_vld_q <= 1'b1;
`endif
          end
        end
        ADDKEY: begin
          state_q <= state_q ^ key_q;
          rcnt_q  <= RFIRST;
          fsm_q   <= ROUND;
        end
        ROUND: begin
          key_q <= key_back;
          if (rcnt_q == 4'd0) begin
            state_q <= arks;
            dout_q  <= arks;
            valid_q <= 1'b1;
            fsm_q   <= IDLE;
          end else begin
            state_q <= mixed;
            rcnt_q  <= rcnt_q - 4'd1;
          end
        end
      endcase
    end
  end

  assign AES_busy           = (fsm_q != IDLE) | valid_q;
  assign AES_data_out       = dout_q;
  assign AES_data_out_valid = valid_q;

endmodule

// File: tb/tb_aes_decrypt_top.sv
// Self-checking bench for aes_decrypt_top: FIPS-197 vectors, random blocks against a
// table-driven full-key-schedule reference model, back-to-back, abort and idle behaviour.
module tb_aes_decrypt_top;
  logic         clk = 1'b0;
  logic         rst, en;
  logic [127:0] data_in, key_in, dout;
  logic         busy, valid;
  int           errors = 0;
  int           checks = 0;

  localparam logic [127:0] K_C1  = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] CT_C1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] PT_C1 = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] K_B   = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] CT_B  = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] PT_B  = 128'h3243f6a8885a308d313198a2e0370734;

  logic [7:0]   sbox_t[256];
  logic [7:0]   isbox_t[256];
  bit           cache_vld = 1'b0;
  logic [127:0] cache_key = '0;

  always #5 clk = ~clk;

  aes_decrypt_top #(.NR(10)) dut (
    .AES_clk           (clk),
    .AES_rst           (rst),
    .AES_en            (en),
    .AES_data_in       (data_in),
    .AES_key_in        (key_in),
    .AES_busy          (busy),
    .AES_data_out      (dout),
    .AES_data_out_valid(valid)
  );

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ a;
      a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // S-box by brute-force inverse search plus the bitwise affine formula
  task automatic build_tables();
    logic [7:0] inv, s, c;
    c = 8'h63;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      for (int b = 0; b < 8; b++)
        s[b] = inv[b] ^ inv[(b+4)%8] ^ inv[(b+5)%8] ^ inv[(b+6)%8] ^ inv[(b+7)%8] ^ c[b];
      sbox_t[x]  = s;
      isbox_t[s] = 8'(x);
    end
  endtask

  function automatic logic [127:0] model_dec(input logic [127:0] k, input logic [127:0] ct);
    logic [31:0]  w[44];
    logic [31:0]  tmp;
    logic [7:0]   s[16], t[16], rc, a0, a1, a2, a3;
    logic [127:0] res;
    for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
    rc = 8'h01;
    for (int i = 4; i < 44; i++) begin
      tmp = w[i-1];
      if (i % 4 == 0) begin
        tmp = {tmp[23:0], tmp[31:24]};
        tmp = {sbox_t[tmp[31:24]], sbox_t[tmp[23:16]], sbox_t[tmp[15:8]], sbox_t[tmp[7:0]]};
        tmp[31:24] = tmp[31:24] ^ rc;
        rc = gmul(rc, 8'h02);
      end
      w[i] = w[i-4] ^ tmp;
    end
    for (int i = 0; i < 16; i++) s[i] = ct[127-8*i -: 8] ^ w[40 + i/4][31-8*(i%4) -: 8];
    for (int r = 9; r >= 0; r--) begin
      for (int i = 0; i < 16; i++) t[(i%4) + 4*(((i/4) + (i%4)) % 4)] = s[i];
      for (int i = 0; i < 16; i++) s[i] = isbox_t[t[i]] ^ w[4*r + i/4][31-8*(i%4) -: 8];
      if (r > 0) begin
        for (int c = 0; c < 4; c++) begin
          a0 = s[4*c]; a1 = s[4*c+1]; a2 = s[4*c+2]; a3 = s[4*c+3];
          s[4*c]   = gmul(a0, 8'd14) ^ gmul(a1, 8'd11) ^ gmul(a2, 8'd13) ^ gmul(a3, 8'd9);
          s[4*c+1] = gmul(a0, 8'd9)  ^ gmul(a1, 8'd14) ^ gmul(a2, 8'd11) ^ gmul(a3, 8'd13);
          s[4*c+2] = gmul(a0, 8'd13) ^ gmul(a1, 8'd9)  ^ gmul(a2, 8'd14) ^ gmul(a3, 8'd11);
          s[4*c+3] = gmul(a0, 8'd11) ^ gmul(a1, 8'd13) ^ gmul(a2, 8'd9)  ^ gmul(a3, 8'd14);
        end
      end
    end
    for (int i = 0; i < 16; i++) res[127-8*i -: 8] = s[i];
    return res;
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  function automatic int exp_lat(input logic [127:0] k);
`ifdef AES_DEC_KEY_CACHE_EN
    if (cache_vld && k == cache_key) return 11;
`endif
    return 21;
  endfunction

  task automatic note_done(input logic [127:0] k);
    cache_vld = 1'b1;
    cache_key = k;
  endtask

  // Start one block, scramble inputs while busy, return latency (-1 on timeout)
  task automatic do_op(input logic [127:0] k, input logic [127:0] ct,
                       output int lat, output int bcnt, output logic [127:0] res);
    @(negedge clk);
    key_in = k; data_in = ct; en = 1'b1;
    @(posedge clk); #1;
    en = 1'b0;
    lat = -1; bcnt = 0; res = '0;
    for (int i = 1; i <= 60; i++) begin
      @(posedge clk); #1;
      if (busy) bcnt++;
      if (valid) begin
        lat = i; res = dout;
        break;
      end
      key_in = rand128(); data_in = rand128();
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b0; data_in = rand128(); key_in = rand128();
    repeat (3) @(posedge clk);
    #1;
    checks++; if (dout !== '0) begin errors++; $display("FAIL reset_dout got %h exp 0", dout); end
    checks++; if (valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
    @(negedge clk); rst = 1'b0;
  endtask

  task automatic test_vector(input string nm, input logic [127:0] k, input logic [127:0] ct,
                             input logic [127:0] pt);
    int lat, bc, el;
    logic [127:0] r;
    el = exp_lat(k);
    do_op(k, ct, lat, bc, r);
    note_done(k);
    checks++; if (r !== pt) begin errors++; $display("FAIL %s_data got %h exp %h", nm, r, pt); end
    checks++; if (lat != el) begin errors++; $display("FAIL %s_latency got %0d exp %0d", nm, lat, el); end
    checks++; if (bc != el) begin errors++; $display("FAIL %s_busy_width got %0d exp %0d", nm, bc, el); end
    @(posedge clk); #1;
    checks++;
    if (valid !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL %s_pulse_end got valid=%b busy=%b exp 0 0", nm, valid, busy);
    end
  endtask

  task automatic test_fips();
    test_vector("c1", K_C1, CT_C1, PT_C1);
    test_vector("b", K_B, CT_B, PT_B);
  endtask

  task automatic test_key_cache();
    test_vector("cache_first", K_C1, CT_C1, PT_C1);
    test_vector("cache_repeat", K_C1, CT_C1, PT_C1);
    test_vector("cache_newkey", K_B, CT_B, PT_B);
  endtask

  task automatic test_back_to_back();
    int n1, n2, el1, el2;
    logic [127:0] r1, r2;
    el1 = exp_lat(K_C1);
    @(negedge clk);
    key_in = K_C1; data_in = CT_C1; en = 1'b1;
    @(posedge clk); #1;
    n1 = -1; r1 = '0;
    for (int i = 1; i <= 60; i++) begin
      @(posedge clk); #1;
      if (valid) begin n1 = i; r1 = dout; break; end
      key_in = rand128(); data_in = rand128();
    end
    note_done(K_C1);
    el2 = exp_lat(K_B);
    key_in = K_B; data_in = CT_B;
    @(posedge clk); #1;
    en = 1'b0;
    n2 = -1; r2 = '0;
    for (int i = 2; i <= 60; i++) begin
      @(posedge clk); #1;
      if (valid) begin n2 = i; r2 = dout; break; end
      key_in = rand128(); data_in = rand128();
    end
    note_done(K_B);
    checks++; if (r1 !== PT_C1) begin errors++; $display("FAIL b2b_first got %h exp %h", r1, PT_C1); end
    checks++; if (r2 !== PT_B) begin errors++; $display("FAIL b2b_second got %h exp %h", r2, PT_B); end
    checks++; if (n1 != el1) begin errors++; $display("FAIL b2b_lat1 got %0d exp %0d", n1, el1); end
    checks++; if (n2 != el2 + 1) begin errors++; $display("FAIL b2b_spacing got %0d exp %0d", n2, el2 + 1); end
    @(posedge clk); #1;
  endtask

  task automatic test_idle_toggle();
    logic [127:0] saved;
    int bad_v, bad_d, bad_b;
    saved = dout; bad_v = 0; bad_d = 0; bad_b = 0;
    repeat (20) begin
      @(negedge clk);
      en = 1'b0; data_in = rand128(); key_in = rand128();
      @(posedge clk); #1;
      if (valid !== 1'b0) bad_v++;
      if (dout !== saved) bad_d++;
      if (busy !== 1'b0) bad_b++;
    end
    checks++; if (bad_v != 0) begin errors++; $display("FAIL idle_valid got %0d pulses exp 0", bad_v); end
    checks++; if (bad_d != 0) begin errors++; $display("FAIL idle_dout got %0d changes exp 0", bad_d); end
    checks++; if (bad_b != 0) begin errors++; $display("FAIL idle_busy got %0d busy cycles exp 0", bad_b); end
  endtask

  task automatic test_random();
    logic [127:0] k, ct, exp_pt, r;
    int lat, bc, el;
    k = rand128();
    for (int n = 0; n < 5; n++) begin
      if (n != 2) k = rand128();
      ct = rand128();
      exp_pt = model_dec(k, ct);
      el = exp_lat(k);
      do_op(k, ct, lat, bc, r);
      note_done(k);
      checks++; if (r !== exp_pt) begin errors++; $display("FAIL rand%0d_data got %h exp %h", n, r, exp_pt); end
      checks++; if (lat != el) begin errors++; $display("FAIL rand%0d_latency got %0d exp %0d", n, lat, el); end
    end
  endtask

  task automatic test_abort();
    int seen, lat, bc, el;
    logic [127:0] r;
    @(negedge clk);
    key_in = K_C1; data_in = CT_C1; en = 1'b1;
    @(posedge clk); #1;
    en = 1'b0;
    repeat (10) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    checks++; if (dout !== '0) begin errors++; $display("FAIL abort_dout got %h exp 0", dout); end
    checks++; if (valid !== 1'b0) begin errors++; $display("FAIL abort_valid got %b exp 0", valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy got %b exp 0", busy); end
    #1 rst = 1'b0;
    cache_vld = 1'b0;
    seen = 0;
    repeat (30) begin
      @(posedge clk); #1;
      if (valid) seen++;
    end
    checks++; if (seen != 0) begin errors++; $display("FAIL abort_no_pulse got %0d pulses exp 0", seen); end
    el = exp_lat(K_B);
    do_op(K_B, CT_B, lat, bc, r);
    note_done(K_B);
    checks++; if (r !== PT_B) begin errors++; $display("FAIL abort_restart got %h exp %h", r, PT_B); end
    checks++; if (lat != el) begin errors++; $display("FAIL abort_restart_lat got %0d exp %0d", lat, el); end
  endtask

  initial begin
    build_tables();
    test_reset();
    test_fips();
    test_key_cache();
    test_back_to_back();
    test_idle_toggle();
    test_random();
    test_abort();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/aes_decrypt_top.md
Name: aes_decrypt_top

Overview:
Iterative AES-128 inverse cipher, one round per clock. It is the decrypt counterpart of the encryption top, with the same enable/valid port style. It takes a 128-bit ciphertext and cipher key, derives round key 10 by forward expansion, then runs the inverse rounds while stepping the key schedule backward on the fly. No 11-entry key store is kept; the result is a 128-bit plaintext with a one-cycle valid strobe.

Parameters:
- NR, 10, number of rounds. Fixed for AES-128; any other value is unsupported.

Ports:
- AES_clk  input  1  system clock, rising edge
- AES_rst  input  1  asynchronous, active-high reset
- AES_en  input  1  start request, sampled only in IDLE
- AES_data_in  input  128  ciphertext; byte 0 = bits [127:120]; FIPS-197 column-major state order
- AES_key_in  input  128  cipher key (not a round key), same byte order
- AES_busy  output  1  high while an operation is in progress
- AES_data_out  output  128  plaintext, held until the next result
- AES_data_out_valid  output  1  one-cycle pulse when AES_data_out updates

Behaviour:
- Reset (async, active-high): FSM to IDLE; AES_data_out=0, AES_data_out_valid=0, AES_busy=0; state, key and counter registers cleared. Reset mid-operation aborts with no valid pulse.
- FSM states: IDLE, KEYEXP, ADDKEY, ROUND.
- IDLE: on an edge with AES_en=1, latch data and key, set rcnt=1, go KEYEXP.
- KEYEXP: 10 cycles, forward expansion rk(i)=f(rk(i-1),Rcon(i)) for rcnt=1..10, then go ADDKEY.
- ADDKEY: state ^= rk10, rcnt=9, go ROUND.
- ROUND: 10 cycles, rcnt 9 down to 0.
  - Key steps backward: w[j-4] = w[j] ^ w[j-1] for j=3,2,1 (j=3 first); w0' = w0 ^ SubWord(RotWord(w3')) ^ Rcon(rcnt+1).
  - state = InvSubBytes(InvShiftRows(state)) ^ rk(rcnt), then InvMixColumns unless rcnt=0.
  - At rcnt=0: write AES_data_out, pulse valid, go IDLE.
- Latency: capture at edge E0; valid is high after edge E0+21 for exactly one cycle.
- AES_busy is high from E0+1 through the cycle in which valid is high.
- Back-to-back: AES_en held high gives the next capture at E0+22; throughput is one block per 22 cycles.
- AES_en and data/key changes while busy are ignored; inputs need only be stable at the capture edge.
- S-box and inverse S-box: combinational functions (GF(2^8) inverse plus affine / inverse affine), no RAM.
- 16 inverse and 4 forward S-box instances.
- InvMixColumns uses xtime-based multiplies by {0e,0b,0d,09}.
- Rcon sequence: 01,02,04,08,10,20,40,80,1b,36.

Optional Feature:
- Macro: AES_DEC_KEY_CACHE_EN.
- Defined:
  - Keep the last cipher key and its rk10.
  - If AES_key_in at capture equals the cached key and the cache is valid, skip KEYEXP: IDLE goes straight to ADDKEY, and valid appears after edge E0+11.
  - Cache is loaded when KEYEXP completes and invalidated by reset.
  - Aborted runs never load the cache.
- Undefined: always 21-cycle latency; no cache registers.

Test Plan:
- FIPS-197 C.1: key 000102030405060708090a0b0c0d0e0f, ct 69c4e0d86a7b0430d8cdb78070b4c55a -> out 00112233445566778899aabbccddeeff, valid exactly 21 cycles after capture, busy width correct.
- FIPS-197 B: key 2b7e151628aed2a6abf7158809cf4f3c, ct 3925841d02dc09fbdc118597196a0b32 -> out 3243f6a8885a308d313198a2e0370734.
- AES_en held high with the C.1 vector then the B vector applied in sequence -> two results, valid pulses 22 cycles apart; input changes during busy ignored.
- AES_rst pulsed at cycle 10 of a run -> outputs 0 immediately, no valid pulse; next start decrypts correctly.
- With AES_DEC_KEY_CACHE_EN: the C.1 vector twice -> second result correct with 11-cycle latency; a key change restores 21 cycles.
- Idle toggling of AES_data_in with AES_en=0 -> AES_data_out and valid unchanged.
